// File: rtl/vga_pixel_fetch.sv
// Three-stage framebuffer fetch for a 640x480 display of a 2x-upscaled image.
// Optional colour-bar background when VGA_TEST_PATTERN_EN is defined.
module vga_pixel_fetch #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              blank_n_in,
  input  logic [9:0]        posx,
  input  logic [8:0]        posy,
  input  logic              img_ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              h_sync_out,
  output logic              v_sync_out,
  output logic              blank_n_out,
  output logic              showing,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHOW
  } state_t;

  localparam logic [31:0] IMG_W_L = 32'(IMG_W);
  localparam logic [31:0] IMG_H_L = 32'(IMG_H);

  state_t state_q, state_d;
  logic [7:0] fc_q, fc_d;
  logic fs;

  logic              s1_rd_q, s1_rd_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              s1_hs_q, s1_vs_q, s1_bn_q;
  state_t            s1_st_q;

  logic   s2_rd_q;
  logic   s2_hs_q, s2_vs_q, s2_bn_q;
  state_t s2_st_q;

  logic [23:0] s3_rgb_q, s3_rgb_d;
  logic        s3_hs_q, s3_vs_q, s3_bn_q;

  logic        vis;
  logic [31:0] addr_full;
  logic [23:0] bg;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] s1_bar_q, s1_bar_d;
  logic [2:0] s2_bar_q;

  function automatic logic [23:0] bar_rgb(logic [2:0] b);
    case (b)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  always_comb begin
    s1_bar_d = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (posx < 10'(80 * (i + 1))) s1_bar_d = 3'(i);
    end
  end

  assign bg = bar_rgb(s2_bar_q);
`else
  assign bg = 24'h000000;
`endif

  // The pixel on the FS cycle already carries the post-FS state.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    fs      = blank_n_in && (posx == 10'd0) && (posy == 9'd0);
    case (state_q)
      IDLE: begin
        if (img_ready) state_d = ARMED;
      end
      ARMED: begin
        if (!img_ready) state_d = IDLE;
        else if (fs) state_d = SHOW;
      end
      SHOW: begin
        if (fs && !img_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fs && state_d == SHOW) fc_d = fc_q + 8'd1;
  end

  always_comb begin
    addr_full = 32'(posy >> 1) * IMG_W_L + 32'(posx >> 1);
    vis = (posx < 10'd640) && (posy < 9'd480) &&
          (32'(posx >> 1) < IMG_W_L) &&
          (32'(posy >> 1) < IMG_H_L);
    s1_rd_d   = blank_n_in && vis && (state_d == SHOW);
    s1_addr_d = s1_rd_d ? addr_full[ADDR_W-1:0] : s1_addr_q;
  end

  always_comb begin
    s3_rgb_d = 24'h000000;
    if (s2_bn_q) begin
      if (s2_st_q == SHOW) begin
        if (s2_rd_q) s3_rgb_d = {3{mem_rdata}};
      end else begin
        s3_rgb_d = bg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      fc_q      <= 8'd0;
      s1_rd_q   <= 1'b0;
      s1_addr_q <= '0;
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
      s1_bn_q   <= 1'b0;
      s1_st_q   <= IDLE;
      s2_rd_q   <= 1'b0;
      s2_hs_q   <= 1'b1;
      s2_vs_q   <= 1'b1;
      s2_bn_q   <= 1'b0;
      s2_st_q   <= IDLE;
      s3_rgb_q  <= 24'h000000;
      s3_hs_q   <= 1'b1;
      s3_vs_q   <= 1'b1;
      s3_bn_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fc_q      <= fc_d;
      s1_rd_q   <= s1_rd_d;
      s1_addr_q <= s1_addr_d;
      s1_hs_q   <= h_sync_in;
      s1_vs_q   <= v_sync_in;
      s1_bn_q   <= blank_n_in;
      s1_st_q   <= state_d;
      s2_rd_q   <= s1_rd_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
      s2_bn_q   <= s1_bn_q;
      s2_st_q   <= s1_st_q;
      s3_rgb_q  <= s3_rgb_d;
      s3_hs_q   <= s2_hs_q;
      s3_vs_q   <= s2_vs_q;
      s3_bn_q   <= s2_bn_q;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_bar_q <= 3'd0;
      s2_bar_q <= 3'd0;
    end else begin
      s1_bar_q <= s1_bar_d;
      s2_bar_q <= s1_bar_q;
    end
  end
`endif

  assign mem_rd      = s1_rd_q;
  assign mem_addr    = s1_addr_q;
  assign red         = s3_rgb_q[23:16];
  assign green       = s3_rgb_q[15:8];
  assign blue        = s3_rgb_q[7:0];
  assign h_sync_out  = s3_hs_q;
  assign v_sync_out  = s3_vs_q;
  assign blank_n_out = s3_bn_q;
  assign showing     = (state_q == SHOW);
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch using compressed frames.
// Expected pixels are queued at drive time and popped 3 cycles later.
module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        h_sync_in = 1'b1;
  logic        v_sync_in = 1'b1;
  logic        blank_n_in = 1'b0;
  logic [9:0]  posx = '0;
  logic [8:0]  posy = '0;
  logic        img_ready = 1'b0;
  logic        mem_rd;
  logic [16:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  red, green, blue;
  logic        h_sync_out, v_sync_out, blank_n_out;
  logic        showing;
  logic [7:0]  frame_cnt;

  vga_pixel_fetch dut (
    .clk(clk), .rst(rst),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .blank_n_in(blank_n_in),
    .posx(posx), .posy(posy),
    .img_ready(img_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .red(red), .green(green), .blue(blue),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .blank_n_out(blank_n_out),
    .showing(showing), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Framebuffer stand-in: data derived from the address.
  always @(posedge clk)
    mem_rdata <= mem_rd ? (mem_addr[7:0] ^ 8'hA5) : 8'h33;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bn;
  } pix_t;

  typedef enum int { M_IDLE, M_ARMED, M_SHOW } mst_t;

  localparam pix_t RST_PIX = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, bn: 1'b0};

  pix_t        sbq[$];
  mst_t        ms = M_IDLE;
  logic [7:0]  mfc = 8'd0;
  logic [16:0] maddr = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bg(input logic [9:0] x);
`ifdef VGA_TEST_PATTERN_EN
    case (int'(x) / 80)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
`else
    return 24'h000000;
`endif
  endfunction

  task automatic px(input logic bn, input logic [9:0] x,
                    input logic [8:0] y);
    logic fs, erd;
    pix_t e, got;
    int ai;
    @(negedge clk);
    rst = 1'b1;
    blank_n_in = bn;
    posx = x;
    posy = y;
    h_sync_in = 1'($urandom);
    v_sync_in = 1'($urandom);
    fs = bn && x == 0 && y == 0;
    case (ms)
      M_IDLE:  if (img_ready) ms = M_ARMED;
      M_ARMED: ms = !img_ready ? M_IDLE : (fs ? M_SHOW : M_ARMED);
      default: if (fs && !img_ready) ms = M_IDLE;
    endcase
    if (fs && ms == M_SHOW) mfc = mfc + 8'd1;
    erd = bn && ms == M_SHOW && x < 640 && y < 480;
    if (erd) begin
      ai = (int'(y) / 2) * 320 + int'(x) / 2;
      maddr = 17'(ai);
    end
    e.hs = h_sync_in;
    e.vs = v_sync_in;
    e.bn = bn;
    if (!bn) e.rgb = 24'h0;
    else if (ms == M_SHOW) e.rgb = erd ? {3{maddr[7:0] ^ 8'hA5}} : 24'h0;
    else e.rgb = bg(x);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check("mem_rd", 32'(mem_rd), 32'(erd));
    check("mem_addr", 32'(mem_addr), 32'(maddr));
    check("showing", 32'(showing), 32'(ms == M_SHOW));
    check("frame_cnt", 32'(frame_cnt), 32'(mfc));
    e = sbq.pop_front();
    got = '{rgb: {red, green, blue}, hs: h_sync_out,
            vs: v_sync_out, bn: blank_n_out};
    check("pixel", 32'(got), 32'(e));
  endtask

  task automatic do_reset(input int n);
    pix_t got;
    @(negedge clk);
    rst = 1'b0;
    repeat (n) begin
      @(negedge clk);
      h_sync_in = 1'($urandom);
      blank_n_in = 1'b1;
      @(posedge clk);
      #1;
      got = '{rgb: {red, green, blue}, hs: h_sync_out,
              vs: v_sync_out, bn: blank_n_out};
      check("rst_pixel", 32'(got), 32'(RST_PIX));
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_showing", 32'(showing), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    end
    ms = M_IDLE;
    mfc = 8'd0;
    maddr = '0;
    sbq.delete();
    sbq.push_back(RST_PIX);
    sbq.push_back(RST_PIX);
  endtask

  task automatic mini_frame();
    px(1'b1, 10'd0, 9'd0);
    repeat (3) px(1'b1, 10'($urandom_range(1, 639)),
                  9'($urandom_range(0, 479)));
    repeat (2) px(1'b0, 10'($urandom_range(0, 799)),
                  9'($urandom_range(0, 511)));
  endtask

  initial begin
    do_reset(3);

    img_ready = 1'b0;
    px(1'b1, 10'd85, 9'd10);
    px(1'b0, 10'd85, 9'd10);
    px(1'b1, 10'd0, 9'd0);
    px(1'b1, 10'd700, 9'd10);
    px(1'b1, 10'd400, 9'd20);

    img_ready = 1'b1;
    px(1'b1, 10'd0, 9'd0);
    px(1'b1, 10'd5, 9'd5);
    px(1'b0, 10'd650, 9'd490);
    px(1'b1, 10'd0, 9'd0);
    check("first_frame_cnt", 32'(frame_cnt), 32'd1);
    px(1'b1, 10'd639, 9'd479);
    px(1'b1, 10'd700, 9'd3);
    px(1'b0, 10'd10, 9'd10);
    px(1'b1, 10'd77, 9'd100);

    img_ready = 1'b0;
    px(1'b1, 10'd33, 9'd200);
    px(1'b1, 10'd100, 9'd300);
    px(1'b0, 10'd700, 9'd500);
    px(1'b1, 10'd0, 9'd0);
    check("drop_showing", 32'(showing), 32'd0);
    px(1'b1, 10'd40, 9'd40);
    px(1'b1, 10'd0, 9'd0);

    img_ready = 1'b1;
    px(1'b1, 10'd0, 9'd0);
    px(1'b1, 10'd0, 9'd0);
    px(1'b1, 10'd10, 9'd10);
    do_reset(2);
    px(1'b1, 10'd0, 9'd0);
    px(1'b1, 10'd3, 9'd3);
    repeat (256) mini_frame();
    check("fc_wrap", 32'(frame_cnt), 32'd0);
    px(1'b0, 10'd0, 9'd0);
    px(1'b0, 10'd0, 9'd0);
    px(1'b0, 10'd0, 9'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
